// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg : bit timing, counter widths and RX state encodings for the UART
// Rev 1.0     : initial release (UART_RX_PARITY_EN selects 8E1 framing)
// ---------------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

  localparam int c_word_w = 8;
  localparam int c_tick_w = 4;
  localparam int c_bit_w  = 3;

  localparam logic [c_tick_w-1:0] c_mid_tick  = 4'd7;
  localparam logic [c_tick_w-1:0] c_last_tick = 4'd15;
  localparam logic [c_bit_w-1:0]  c_last_bit  = 3'd7;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    RXIDLE   = 3'd0,
    RXSTART  = 3'd1,
    RXBIT    = 3'd2,
    RXSTOP   = 3'd3,
    RXPARITY = 3'd4
  } rx_state_t;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic f_parity_err(input logic [c_word_w-1:0] i_data,
                                        input logic i_par);
    return i_par ^ (^i_data);
  endfunction
`else
  typedef enum logic [2:0] {
    RXIDLE  = 3'd0,
    RXSTART = 3'd1,
    RXBIT   = 3'd2,
    RXSTOP  = 3'd3
  } rx_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if : serial line and host-side signals of the UART receiver
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                serin;
  logic                host_rd;
  logic [c_word_w-1:0] dout;
  logic                rx_full;
  logic                framing_err;
  logic                overrun;
  logic                parity_err;

  modport master (
    output serin, host_rd,
    input  dout, rx_full, framing_err, overrun, parity_err
  );

  modport slave (
    input  serin, host_rd,
    output dout, rx_full, framing_err, overrun, parity_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2 : two-flop synchronizer, falling-edge clocked, resets to idle (1)
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_sync2 (
  input  wire logic clk,
  input  wire logic reset_b,
  input  wire logic i_async,
  output logic      o_sync
);

  logic [1:0] r_sync;

  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  assign o_sync = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 16x oversampled 8N1 receiver; define UART_RX_PARITY_EN for 8E1
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset_b,
  uart_rx_if.slave  bus
);

  logic                w_serin_s;
  logic                w_complete;

  rx_state_t           r_state;
  logic [c_tick_w-1:0] r_tick;
  logic [c_bit_w-1:0]  r_bit;
  logic [c_word_w-1:0] r_shift;
  logic                r_brk;
  logic [c_word_w-1:0] r_dout;
  logic                r_full;
  logic                r_fe;
  logic                r_ov;
`ifdef UART_RX_PARITY_EN
  logic                r_par_bit;
  logic                r_pe;
`endif

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .i_async (bus.serin),
    .o_sync  (w_serin_s)
  );

  // Only the first stop-bit sample of a frame completes it; a held break does not.
  assign w_complete = (r_state == RXSTOP) && !r_brk && (r_tick == c_last_tick);

  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= RXIDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_brk     <= 1'b0;
      r_dout    <= '0;
      r_full    <= 1'b0;
      r_fe      <= 1'b0;
      r_ov      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit <= 1'b0;
      r_pe      <= 1'b0;
`endif
    end else begin
      case (r_state)
        RXIDLE: begin
          if (!w_serin_s) begin
            r_state <= RXSTART;
            r_tick  <= '0;
          end
        end
        RXSTART: begin
          if (r_tick == c_mid_tick) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= w_serin_s ? RXIDLE : RXBIT;
          end else begin
            r_tick <= r_tick + 4'd1;
          end
        end
        RXBIT: begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == c_last_tick) begin
            r_shift <= {w_serin_s, r_shift[c_word_w-1:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == c_last_bit) begin
`ifdef UART_RX_PARITY_EN
              r_state <= RXPARITY;
`else
              r_state <= RXSTOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RXPARITY: begin
          r_tick <= r_tick + 4'd1;
          if (r_tick == c_last_tick) begin
            r_par_bit <= w_serin_s;
            r_state   <= RXSTOP;
          end
        end
`endif
        RXSTOP: begin
          if (r_brk) begin
            if (w_serin_s) begin
              r_brk   <= 1'b0;
              r_state <= RXIDLE;
            end
          end else begin
            r_tick <= r_tick + 4'd1;
            if (r_tick == c_last_tick) begin
              if (w_serin_s) begin
                r_state <= RXIDLE;
              end else begin
                r_brk <= 1'b1;
              end
            end
          end
        end
        default: r_state <= RXIDLE;
      endcase

      if (w_complete) begin
        if (!r_full || bus.host_rd) begin
          r_dout <= r_shift;
          r_full <= 1'b1;
          r_fe   <= ~w_serin_s;
          r_ov   <= 1'b0;
`ifdef UART_RX_PARITY_EN
          r_pe   <= f_parity_err(r_shift, r_par_bit);
`endif
        end else begin
          r_ov <= 1'b1;
        end
      end else if (bus.host_rd && r_full) begin
        r_full <= 1'b0;
        r_fe   <= 1'b0;
        r_ov   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_pe   <= 1'b0;
`endif
      end
    end
  end

  assign bus.dout        = r_dout;
  assign bus.rx_full     = r_full;
  assign bus.framing_err = r_fe;
  assign bus.overrun     = r_ov;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err  = r_pe;
`else
  assign bus.parity_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx (8N1, or 8E1 with UART_RX_PARITY_EN)
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int   c_ext = 16;
  localparam logic c_par = 1'b1;
`else
  localparam int   c_ext = 0;
  localparam logic c_par = 1'b0;
`endif
  localparam int c_lat_min = 152 + c_ext;
  localparam int c_lat_max = 156 + c_ext;
  localparam int c_done    = 154 + c_ext;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_b = 1'b0;
  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_if bus();

  uart_rx dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe, input logic ov);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe; e.ov = ov;
    q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    bus.serin = b;
    repeat (16) @(posedge clk);
  endtask

  // Line is left low after a low stop bit so break handling can be exercised.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop);
    if (stop) bus.serin = 1'b1;
  endtask

  task automatic host_read();
    bus.host_rd = 1'b1;
    @(posedge clk);
    bus.host_rd = 1'b0;
  endtask

  // Monitor: every load or overrun event consumes one expectation.
  logic       prev_full = 1'b0;
  logic       prev_ov   = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  always @(posedge clk) begin
    exp_t e;
    if (reset_b && ((bus.rx_full && !prev_full) ||
                    (bus.rx_full && prev_full && bus.dout != prev_dout) ||
                    (bus.overrun && !prev_ov))) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: dout=0x%0h rx_full=%0b overrun=%0b, expected no event",
                 bus.dout, bus.rx_full, bus.overrun);
      end else begin
        e = q.pop_front();
        check("mon_dout",        bus.dout,        e.d);
        check("mon_framing_err", bus.framing_err, e.fe);
        check("mon_parity_err",  bus.parity_err,  e.pe);
        check("mon_overrun",     bus.overrun,     e.ov);
      end
    end
    prev_full <= bus.rx_full;
    prev_ov   <= bus.overrun;
    prev_dout <= bus.dout;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] v;
    bus.serin   = 1'b1;
    bus.host_rd = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_dout",        bus.dout,        8'h00);
    check("rst_rx_full",     bus.rx_full,     1'b0);
    check("rst_framing_err", bus.framing_err, 1'b0);
    check("rst_overrun",     bus.overrun,     1'b0);
    check("rst_parity_err",  bus.parity_err,  1'b0);
    reset_b = 1'b1;
    repeat (20) @(posedge clk);
    check("idle_no_start", bus.rx_full, 1'b0);

    // 0x55 with latency measurement
    push(8'h55, 1'b0, 1'b0, 1'b0);
    lat = 0;
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        wait (bus.serin === 1'b0);
        while (!bus.rx_full && lat < 300) begin
          @(posedge clk);
          lat++;
        end
      end
    join
    n_checks++;
    if (lat < c_lat_min || lat > c_lat_max) begin
      n_fail++;
      $display("FAIL latency: got %0d clk, expected %0d..%0d", lat, c_lat_min, c_lat_max);
    end
    host_read();
    check("read_clears_full", bus.rx_full, 1'b0);

    // Short glitch must not start a frame
    bus.serin = 1'b0;
    repeat (4) @(posedge clk);
    bus.serin = 1'b1;
    repeat (30) @(posedge clk);
    check("glitch_no_full", bus.rx_full, 1'b0);
    push(8'hA3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    host_read();

    // Overrun: second byte dropped
    push(8'h12, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0);
    push(8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    check("ovr_dout_kept", bus.dout, 8'h12);
    host_read();
    check("ovr_rd_full",    bus.rx_full,     1'b0);
    check("ovr_rd_overrun", bus.overrun,     1'b0);
    check("ovr_rd_fe",      bus.framing_err, 1'b0);

    // Low stop bit followed by a break
    push(8'h7E, 1'b1, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    check("brk_framing_err", bus.framing_err, 1'b1);
    bus.serin = 1'b1;
    repeat (32) @(posedge clk);
    host_read();
    push(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    check("after_brk_fe", bus.framing_err, 1'b0);
    host_read();

    // host_rd coincides with completion of the second byte
    push(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    push(8'hC6, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'hC6, 1'b1, 1'b0);
      begin
        repeat (c_done) @(posedge clk);
        bus.host_rd = 1'b1;
        @(posedge clk);
        bus.host_rd = 1'b0;
      end
    join
    check("same_cycle_full",    bus.rx_full, 1'b1);
    check("same_cycle_overrun", bus.overrun, 1'b0);
    check("same_cycle_dout",    bus.dout,    8'hC6);
    host_read();

    // Reset during the 4th data bit with an unread byte held
    push(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    v = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(v[i]);
    bus.serin = v[3];
    repeat (6) @(posedge clk);
    reset_b   = 1'b0;
    bus.serin = 1'b1;
    #1;
    check("midrst_dout",        bus.dout,        8'h00);
    check("midrst_rx_full",     bus.rx_full,     1'b0);
    check("midrst_framing_err", bus.framing_err, 1'b0);
    check("midrst_overrun",     bus.overrun,     1'b0);
    check("midrst_parity_err",  bus.parity_err,  1'b0);
    @(posedge clk);
    reset_b = 1'b1;
    repeat (20) @(posedge clk);
    check("midrst_no_start", bus.rx_full, 1'b0);
    push(8'hC3, 1'b0, c_par, 1'b0);
    send_frame(8'hC3, 1'b1, c_par);
    host_read();

    repeat (20) @(posedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port: clk  input  1  bit-tick clock, 16 ticks per bit; all state updates on falling edge of clk.
REQ-002 SHALL have port: reset_b  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: serin  input  1  asynchronous serial line; idle high, 8N1, LSB first.
REQ-004 SHALL have port: dout  output  8  last received byte.
REQ-005 SHALL have port: host_rd  input  1  one-cycle acknowledge that the host has taken dout.
REQ-006 SHALL have port: rx_full  output  1  dout holds an unread byte.
REQ-007 SHALL have port: framing_err  output  1  stop bit of the byte in dout sampled low.
REQ-008 SHALL have port: overrun  output  1  a completed byte was dropped because rx_full was set.
REQ-009 SHALL have port: parity_err  output  1  parity mismatch on the byte in dout; constant 0 unless UART_RX_PARITY_EN is defined.

Function
REQ-010 SHALL pass serin through a 2-flop synchronizer (serin_s) before any use.
REQ-011 SHALL implement states RXIDLE, RXSTART, RXBIT, RXPARITY (parity builds only) and RXSTOP, with a 4-bit tick counter and a 3-bit bit counter.
REQ-012 RXIDLE: serin_s==0 -> RXSTART, tick counter cleared.
REQ-013 RXSTART: tick counter==7 (mid start bit) -> clear tick and bit counters; serin_s==0 -> RXBIT; serin_s==1 -> RXIDLE (false start, no flag).
REQ-014 RXBIT: tick counter==15 -> sample serin_s into shift register MSB, shifting right, and increment bit counter; the 8th sample -> RXPARITY if parity is enabled, otherwise RXSTOP.
REQ-015 RXSTOP: tick counter==15 -> sample stop bit, then complete the byte (REQ-016); stop==1 -> RXIDLE; stop==0 -> hold in RXSTOP until serin_s==1, then RXIDLE (break handling, no further completions).
REQ-016 Byte completion with rx_full==0 or host_rd==1: load dout, set rx_full, and set framing_err and parity_err from this frame.
REQ-017 Byte completion with rx_full==1 and host_rd==0: discard the byte, keep dout and its flags, set overrun.
REQ-018 host_rd without a same-cycle completion: clear rx_full, framing_err, parity_err and overrun at the next edge; host_rd with rx_full==0 has no effect.
REQ-019 Byte latency: rx_full rises 152-156 clk after the serin falling edge that starts the frame (8N1).

Reset
REQ-020 reset_b low: all outputs and flags 0, dout 8'h00, state RXIDLE, counters 0, synchronizer flops 1; applies immediately, including mid-frame.
REQ-021 After reset release: no spurious start is detected while serin is high.

Configuration
REQ-022 UART_RX_PARITY_EN defined: frame is 8E1; RXPARITY samples the parity bit at tick counter==15; parity_err = received parity bit XOR XOR(data bits); latency +16 clk.
REQ-023 UART_RX_PARITY_EN undefined: no RXPARITY state or parity logic; parity_err is tied to 0.

Structure
REQ-024 Shared header uart.vh SHALL hold ticks-per-bit, mid-bit tick, word size, counter widths and the RX state encodings, shared with the transmitter.
REQ-025 The synchronizer SHALL be the sub-module uart_sync2 (2 flops, async reset to 1).

Verification
REQ-026 8N1 frame carrying 0x55 from idle -> dout=0x55, rx_full=1 at clk 152-156, framing_err=0, overrun=0.
REQ-027 0x00 glitch on serin for 4 clk -> no rx_full, state returns to RXIDLE, next frame 0xA3 received correctly.
REQ-028 Frames 0x12 then 0x34 with no host_rd -> dout=0x12, overrun=1; host_rd -> rx_full, overrun and framing_err all 0.
REQ-029 Frame 0x7E with stop bit low, then line held low for 40 clk -> dout=0x7E, framing_err=1, single completion, next 0x81 received after line returns high.
REQ-030 host_rd in the same cycle as completion of the 2nd byte -> rx_full stays 1, dout = 2nd byte, overrun=0.
REQ-031 reset_b pulsed low during the 4th data bit -> all outputs 0; next full frame 0xC3 received correctly; with UART_RX_PARITY_EN, a bad parity bit gives parity_err=1.
